// File: rtl/saida_pkg.sv
// Shared types and constants for the output-data BCD unit.
// Optional feature macro: SAIDA_SEG7_EN (seven-segment decoders on the display path).
package saida_pkg;

   // Conversion FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } saida_state_e;

   // Active-low gfedcba patterns for decimal digits
   localparam logic [6:0] SEG7_0     = 7'b1000000;
   localparam logic [6:0] SEG7_1     = 7'b1111001;
   localparam logic [6:0] SEG7_2     = 7'b0100100;
   localparam logic [6:0] SEG7_3     = 7'b0110000;
   localparam logic [6:0] SEG7_4     = 7'b0011001;
   localparam logic [6:0] SEG7_5     = 7'b0010010;
   localparam logic [6:0] SEG7_6     = 7'b0000010;
   localparam logic [6:0] SEG7_7     = 7'b1111000;
   localparam logic [6:0] SEG7_8     = 7'b0000000;
   localparam logic [6:0] SEG7_9     = 7'b0010000;
   localparam logic [6:0] SEG7_BLANK = 7'h7F;

   // Decimal digits needed to hold any W-bit unsigned value: floor(W*log10(2)) + 1
   function automatic int nibbles_needed(input int w);
      return (w * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bcd_seg7_dec.sv
// One BCD digit to active-low seven-segment pattern, with blanking input.
// Used only when SAIDA_SEG7_EN is defined.
module bcd_seg7_dec
   import saida_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank_in,
   output logic [6:0] seg
);

   // Pattern lookup; codes above 9 and blanked digits show nothing
   always_comb begin
      seg = SEG7_BLANK;
      if (!blank_in) begin
         case (bcd)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/saida_dados_bcd.sv
// Output-data unit: latches the processor output word on saida and converts its
// magnitude to packed BCD with a serial double-dabble engine (one bit per clock).
// Optional: SAIDA_SEG7_EN adds a registered seven-segment output per digit.
//
// Handshake: a write (out=1) is taken only in a cycle where busy=0; writes while
// busy=1 are dropped. busy rises the cycle after acceptance and falls after the
// single-cycle valid pulse, during which digitos/neg/ovf (and segmentos) are new.
module saida_dados_bcd
   import saida_pkg::*;
#(
   parameter int W      = 32,
   parameter int ND     = 10,
   parameter bit SIGNED = 1'b1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            out,
   input  logic [W-1:0]    dados,
   output logic [W-1:0]    saida,
   output logic [4*ND-1:0] digitos,
   output logic            neg,
   output logic            busy,
   output logic            valid,
   output logic            ovf,
   output saida_state_e    state_dbg
`ifdef SAIDA_SEG7_EN
   ,
   output logic [7*ND-1:0] segmentos
`endif
);

   localparam int CW = $clog2(W + 1);

   if (ND < 1 || W < 2) begin : g_param_check
      $error("saida_dados_bcd: need ND >= 1 and W >= 2");
   end

   saida_state_e    state_q, state_d;
   logic [W-1:0]    saida_q, saida_d;
   logic [W-1:0]    mag_q, mag_d;
   logic [4*ND-1:0] bcd_q, bcd_d;
   logic [4*ND-1:0] digitos_q, digitos_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_int_q, neg_int_d;
   logic            neg_q, neg_d;
   logic            ovf_int_q, ovf_int_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;

   logic [4*ND-1:0] bcd_adj;
   logic [4*ND-1:0] bcd_sh;
   logic            shift_ovf;
   logic            sign_in;

   // Add-3 correction on every nibble, then shift the next magnitude bit in
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < ND; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
      bcd_sh    = {bcd_adj[4*ND-2:0], mag_q[W-1]};
      shift_ovf = bcd_adj[4*ND-1];
   end

`ifdef SAIDA_SEG7_EN
   logic [7*ND-1:0] seg_q, seg_d, seg_next;
   logic [ND:0]     lead_zero;

   // Leading-zero chain from the top digit down; digit 0 is always shown
   assign lead_zero[ND] = 1'b1;
   for (genvar g = ND - 1; g >= 0; g--) begin : g_seg
      assign lead_zero[g] = lead_zero[g+1] && (bcd_sh[4*g +: 4] == 4'd0);
      bcd_seg7_dec u_dec (
         .bcd      (bcd_sh[4*g +: 4]),
         .blank_in ((g != 0) && lead_zero[g]),
         .seg      (seg_next[7*g +: 7])
      );
   end
`endif

   // Next-state and next-output logic for the conversion FSM
   always_comb begin
      state_d   = state_q;
      saida_d   = saida_q;
      mag_d     = mag_q;
      bcd_d     = bcd_q;
      digitos_d = digitos_q;
      cnt_d     = cnt_q;
      neg_int_d = neg_int_q;
      neg_d     = neg_q;
      ovf_int_d = ovf_int_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      sign_in   = SIGNED && dados[W-1];
`ifdef SAIDA_SEG7_EN
      seg_d     = seg_q;
`endif
      case (state_q)
         IDLE: begin
            if (out) begin
               saida_d   = dados;
               neg_int_d = sign_in;
               mag_d     = sign_in ? (~dados + W'(1)) : dados;
               bcd_d     = '0;
               ovf_int_d = 1'b0;
               cnt_d     = CW'(W);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d     = bcd_sh;
            mag_d     = mag_q << 1;
            ovf_int_d = ovf_int_q | shift_ovf;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               // Publish on the last shift so results are valid together with the pulse
               digitos_d = bcd_sh;
               ovf_d     = ovf_int_q | shift_ovf;
               neg_d     = neg_int_q;
               valid_d   = 1'b1;
               state_d   = DONE;
`ifdef SAIDA_SEG7_EN
               seg_d     = seg_next;
`endif
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         saida_q   <= '0;
         mag_q     <= '0;
         bcd_q     <= '0;
         digitos_q <= '0;
         cnt_q     <= '0;
         neg_int_q <= 1'b0;
         neg_q     <= 1'b0;
         ovf_int_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
`ifdef SAIDA_SEG7_EN
         seg_q     <= {ND{SEG7_BLANK}};
`endif
      end else begin
         state_q   <= state_d;
         saida_q   <= saida_d;
         mag_q     <= mag_d;
         bcd_q     <= bcd_d;
         digitos_q <= digitos_d;
         cnt_q     <= cnt_d;
         neg_int_q <= neg_int_d;
         neg_q     <= neg_d;
         ovf_int_q <= ovf_int_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
`ifdef SAIDA_SEG7_EN
         seg_q     <= seg_d;
`endif
      end
   end

   assign saida     = saida_q;
   assign digitos   = digitos_q;
   assign neg       = neg_q;
   assign busy      = busy_q;
   assign valid     = valid_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;
`ifdef SAIDA_SEG7_EN
   assign segmentos = seg_q;
`endif

endmodule

// File: tb/tb_saida_dados_bcd.sv
// Bench for saida_dados_bcd: three instances (signed 10 digits, unsigned 10 digits,
// unsigned 4 digits) share one stimulus stream; results are compared against a
// decimal reference computed with integer division.
module tb_saida_dados_bcd;
   import saida_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   logic out;
   logic [W-1:0] dados;

   always #5 clock = ~clock;

   logic [W-1:0]  saida_a, saida_u, saida_s;
   logic [39:0]   dig_a, dig_u;
   logic [15:0]   dig_s;
   logic          neg_a, neg_u, neg_s;
   logic          busy_a, busy_u, busy_s;
   logic          valid_a, valid_u, valid_s;
   logic          ovf_a, ovf_u, ovf_s;
   saida_state_e  st_a, st_u, st_s;
`ifdef SAIDA_SEG7_EN
   logic [69:0]   seg_a, seg_u;
   logic [27:0]   seg_s;
`endif

   saida_dados_bcd #(.W(W), .ND(10), .SIGNED(1'b1)) dut_a (
      .clock(clock), .reset_n(reset_n), .out(out), .dados(dados),
      .saida(saida_a), .digitos(dig_a), .neg(neg_a), .busy(busy_a),
      .valid(valid_a), .ovf(ovf_a), .state_dbg(st_a)
`ifdef SAIDA_SEG7_EN
      , .segmentos(seg_a)
`endif
   );

   saida_dados_bcd #(.W(W), .ND(10), .SIGNED(1'b0)) dut_u (
      .clock(clock), .reset_n(reset_n), .out(out), .dados(dados),
      .saida(saida_u), .digitos(dig_u), .neg(neg_u), .busy(busy_u),
      .valid(valid_u), .ovf(ovf_u), .state_dbg(st_u)
`ifdef SAIDA_SEG7_EN
      , .segmentos(seg_u)
`endif
   );

   saida_dados_bcd #(.W(W), .ND(4), .SIGNED(1'b0)) dut_s (
      .clock(clock), .reset_n(reset_n), .out(out), .dados(dados),
      .saida(saida_s), .digitos(dig_s), .neg(neg_s), .busy(busy_s),
      .valid(valid_s), .ovf(ovf_s), .state_dbg(st_s)
`ifdef SAIDA_SEG7_EN
      , .segmentos(seg_s)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [39:0]  last_dig_a;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: magnitude by arithmetic, digits by repeated division
   task automatic model(input logic [W-1:0] d, input bit sgn, input int nd,
                        output logic [39:0] dig, output bit ng, output bit ov);
      longint unsigned v;
      ng  = sgn && d[W-1];
      v   = ng ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
      dig = '0;
      for (int i = 0; i < nd; i++) begin
         dig[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      ov = (v != 0);
   endtask

`ifdef SAIDA_SEG7_EN
   function automatic logic [69:0] seg_model(input logic [39:0] dig);
      logic [6:0] tbl [10];
      logic [69:0] s;
      bit lz;
      logic [3:0] nib;
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      s  = '0;
      lz = 1'b1;
      for (int i = 9; i >= 0; i--) begin
         nib = dig[4*i +: 4];
         if (i > 0 && lz && nib == 4'd0) s[7*i +: 7] = 7'h7F;
         else begin
            lz = 1'b0;
            s[7*i +: 7] = (nib <= 4'd9) ? tbl[nib] : 7'h7F;
         end
      end
      return s;
   endfunction
`endif

   task automatic check_result();
      logic [W-1:0] d;
      logic [39:0]  e_dig;
      bit e_ng, e_ov;
      d = exp_q.pop_front();
      model(d, 1'b1, 10, e_dig, e_ng, e_ov);
      check("a_digitos", dig_a, e_dig);
      check("a_neg", neg_a, e_ng);
      check("a_ovf", ovf_a, e_ov);
      last_dig_a = e_dig;
`ifdef SAIDA_SEG7_EN
      check("a_segmentos", seg_a, seg_model(e_dig));
`endif
      model(d, 1'b0, 10, e_dig, e_ng, e_ov);
      check("u_digitos", dig_u, e_dig);
      check("u_neg", neg_u, e_ng);
      check("u_ovf", ovf_u, e_ov);
      model(d, 1'b0, 4, e_dig, e_ng, e_ov);
      check("s_digitos", dig_s, e_dig[15:0]);
      check("s_ovf", ovf_s, e_ov);
   endtask

   // ---------------- driver tasks (entered just after a negedge) ----------------
   task automatic send(input logic [W-1:0] d);
      out   = 1'b1;
      dados = d;
      @(posedge clock);
      @(negedge clock);
      out   = 1'b0;
      dados = $urandom;
      check("accept_busy", {busy_a, busy_u, busy_s}, 3'b111);
      check("accept_saida", saida_a, d);
      exp_q.push_back(d);
   endtask

   task automatic wait_done(input int exp_edges);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < exp_edges + 8) begin
         @(negedge clock);
         n++;
         if (valid_a) seen = 1'b1;
      end
      check("latency", n, exp_edges);
      if (seen) begin
         check("valid_all", {valid_u, valid_s}, 2'b11);
         check("scoreboard_entry", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check_result();
      end
      @(negedge clock);
      check("valid_pulse_end", {valid_a, busy_a}, 2'b00);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_a"}, {saida_a, dig_a, neg_a, busy_a, valid_a, ovf_a}, '0);
      check({tag, "_u"}, {saida_u, dig_u, neg_u, busy_u, valid_u, ovf_u}, '0);
      check({tag, "_s"}, {saida_s, dig_s, neg_s, busy_s, valid_s, ovf_s}, '0);
      check({tag, "_state"}, st_a, IDLE);
`ifdef SAIDA_SEG7_EN
      check({tag, "_seg"}, seg_a, {70{1'b1}});
`endif
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [W-1:0] directed [8];
      logic [W-1:0] edge_vals [6];
      logic [W-1:0] v;
      int valid_seen;

      directed  = '{32'd1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                    32'd7, 32'd99999999, 32'h7FFF_FFFF, 32'd10000};
      edge_vals = '{32'd9, 32'd10, 32'd9999, 32'hFFFF_FFFE, 32'h8000_0001, 32'd1};

      reset_n    = 1'b0;
      out        = 1'b0;
      dados      = '0;
      last_dig_a = '0;
      repeat (3) @(negedge clock);
      check_reset_state("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // Directed values, each sent the cycle after the previous conversion retires
      for (int i = 0; i < 8; i++) begin
         send(directed[i]);
         wait_done(W);
      end

      // Write during conversion must be dropped
      send(32'd4321);
      repeat (4) @(negedge clock);
      out   = 1'b1;
      dados = 32'd99;
      @(negedge clock);
      out   = 1'b0;
      check("ignored_saida", saida_a, 32'd4321);
      check("ignored_busy", busy_a, 1'b1);
      check("hold_digitos", dig_a, last_dig_a);
      wait_done(W - 5);

      // Reset in the middle of a conversion aborts it without a valid pulse
      send(32'd555);
      repeat (10) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check_reset_state("midreset");
      reset_n = 1'b1;
      exp_q.delete();
      last_dig_a = '0;
      valid_seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (valid_a || busy_a) valid_seen++;
      end
      check("no_valid_after_abort", valid_seen, 0);
      send(32'd1000);
      wait_done(W);

      // Randomized values with a bias toward small, negative and edge cases
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = W'($urandom_range(0, 9999));
            2:       v = -W'($urandom_range(1, 100000));
            default: v = edge_vals[$urandom_range(0, 5)];
         endcase
         send(v);
         wait_done(W);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
